spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable SPI flash-style responder: the far end of the SPI master link, answering the command/address/dummy/data sequences the master issues in single, dual and quad lane modes. It oversamples the SPI pins with the system clock, decodes a fixed command set, and serves reads/writes through a simple word-wide backend port. It is used as an on-chip memory target for the SPI master in simulation and FPGA loopback builds.

## Interface
- DUMMY_CYCLES, 8: sclk rising edges skipped between address and data for fast/dual/quad reads (1..15)
- JEDEC_ID, 24'hC22017: value returned by READ ID
- clk  in  1  system clock; must run at ≥8× sclk
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock from master, mode 0 (idle low)
- cs_n  in  1  chip select, active-low
- io_in  in  4  SPI data lines in; io_in[0] = MOSI
- io_out  out  4  SPI data lines out; io_out[1] = MISO in single mode
- io_oe  out  4  per-line output enable
- rd_req  out  1  one-clk pulse: fetch word at rd_addr
- rd_addr  out  24  word-aligned byte address (bits [1:0] = 0)
- rd_ack  in  1  one-clk pulse; rd_data valid in the same cycle
- rd_data  in  32  read word, shifted out MSB first
- wr_en  out  1  one-clk pulse: store wr_data at wr_addr
- wr_addr  out  24  word-aligned byte address
- wr_data  out  32  assembled write word, first received bit = bit 31
- busy  out  1  high while cs_n (synchronized) is low
- underrun  out  1  one-clk pulse: read data not available at drive edge
- cmd_err  out  1  one-clk pulse: unsupported command decoded

## Operation
- sclk, cs_n and io_in pass through 2-FF synchronizers; a third sclk register provides rise/fall strobes.
- Sample on sclk rise, drive io_out on sclk fall; all logic runs on clk.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, ID, IGNORE.
- IDLE→CMD on synchronized cs_n fall. CMD: shift 8 bits from io_in[0].
- Commands:
  - 0x03: ADDR, then RDATA single.
  - 0x0B: ADDR, DUMMY, then RDATA single.
  - 0x3B: as 0x0B with RDATA dual.
  - 0x6B: as 0x0B with RDATA quad.
  - 0x02: ADDR, then WDATA single.
  - 0x9F: ID.
  - Other: IGNORE, with a cmd_err pulse.
- ADDR: 24 bits on io_in[0], MSB first. On the 24th rise, issue rd_req with rd_addr = {addr[23:2],2'b00} for read commands, or load wr_addr for 0x02. The low 2 address bits are ignored.
- DUMMY: count DUMMY_CYCLES rises with io_oe = 0.
- RDATA drive:
  - Single: io_out[1], io_oe = 4'b0010.
  - Dual: {io_out[1],io_out[0]}, io_oe = 4'b0011, [1] is MSB.
  - Quad: io_out[3:0], io_oe = 4'hF, [3] is MSB.
- RDATA buffering: the word latched on rd_ack goes to the shift register at the first drive fall of each word. The next rd_req (address +4, wraps at 24'hFFFFFC→0) issues on that same fall, prefetching into a holding register.
- RDATA underrun: if no word is held at a word-start fall, drive all ones for that word and pulse underrun.
- ID: shift JEDEC_ID MSB first on io_out[1], 24 bits, then drive ones.
- WDATA: shift io_in[0] into a 32-bit register. Every 32nd rise pulses wr_en, then wr_addr += 4 (same wrap).
- cs_n rise, from any state: return to IDLE next clk. io_oe = 0, counters cleared, a partial write word is dropped, a pending rd_ack is ignored.

## Timing
- Reset values: io_out = 0, io_oe = 0, rd_req = 0, rd_addr = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, underrun = 0, cmd_err = 0. State is IDLE.
- Pin-to-strobe latency: 3 clk. busy rises/falls 2 clk after cs_n.
- The first data bit is driven on the sclk fall following the last address (or dummy) rise. io_oe asserts the clk after that fall.
- rd_ack is required within 2 clk of rd_req; the backend is allowed at most one outstanding request.
- wr_en and wr_data update 1 clk after the 32nd sampling strobe. wr_addr increments the clk after wr_en.
- cmd_err pulses 1 clk after the 8th command strobe.
- An edge coincident with cs_n rise is discarded.

## Test plan
- 0x9F, 24 clocks of readback -> MISO returns 0xC22017 MSB first, then 1s; io_oe = 4'b0010 only during data.
- 0x03 addr 0x000104, backend rd_data = 0xDEADBEEF for 0x104 and 0x01234567 for 0x108, read 64 bits -> rd_addr 0x104 then 0x108, bits DEADBEEF01234567.
- 0x6B addr 0x000010, 8 dummy, backend never acks -> underrun pulse, eight nibbles 0xF, io_oe = 4'hF.
- 0x02 addr 0x000020, 40 data bits then cs_n high -> one wr_en with wr_addr 0x20 and the first 32 bits; trailing 8 bits dropped.
- Command 0x5A -> cmd_err pulse, io_oe stays 0 until cs_n high; the next 0x9F transaction works.
- rst_n low mid-RDATA -> all outputs at reset values immediately; after release, 0x3B addr 0 returns dual data correctly.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI flash-style target (single/dual/quad reads, single writes, READ ID)
// oversampling the SPI pins on clk and serving data through a word-wide backend port.
module spi_flash_responder #(
   parameter int          DUMMY_CYCLES = 8,
   parameter logic [23:0] JEDEC_ID     = 24'hC22017
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic [3:0]  io_in,
   output logic [3:0]  io_out,
   output logic [3:0]  io_oe,
   output logic        rd_req,
   output logic [23:0] rd_addr,
   input  logic        rd_ack,
   input  logic [31:0] rd_data,
   output logic        wr_en,
   output logic [23:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        underrun,
   output logic        cmd_err
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, ID, IGNORE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sclk_q;
   logic [1:0]  cs_q, io_q;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [23:0] addr_q, addr_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [31:0] shift_q, shift_d, hold_q, hold_d, wr_data_q, wr_data_d;
   logic [3:0]  io_out_q, io_out_d, io_oe_q, io_oe_d;
   logic        hold_v_q, hold_v_d, pend_q, pend_d;
   logic        rd_req_q, rd_req_d, wr_en_q, wr_en_d, underrun_q, underrun_d, cmd_err_q, cmd_err_d;

   logic        rise, fall, quad, dual, rd_cmd;
   logic [7:0]  cmd_sh;
   logic [23:0] addr_sh;
   logic [31:0] wsh, word;
   logic [5:0]  last;

   assign rise    = sclk_q[1] & ~sclk_q[2];
   assign fall    = ~sclk_q[1] & sclk_q[2];
   assign cmd_sh  = {cmd_q[6:0], io_q[1]};
   assign addr_sh = {addr_q[22:0], io_q[1]};
   assign wsh     = {shift_q[30:0], io_q[1]};
   assign quad    = cmd_q == 8'h6B;
   assign dual    = cmd_q == 8'h3B;
   assign rd_cmd  = cmd_q inside {8'h03, 8'h0B, 8'h3B, 8'h6B};
   assign last    = quad ? 6'd7 : dual ? 6'd15 : 6'd31;
   // Word start loads the prefetched word, or all ones if the backend has not delivered
   assign word    = cnt_q != 6'd0 ? shift_q : hold_v_q ? hold_q : '1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      hold_v_d   = hold_v_q;
      pend_d     = pend_q;
      io_out_d   = io_out_q;
      io_oe_d    = io_oe_q;
      rd_req_d   = 1'b0;
      rd_addr_d  = rd_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_en_q ? wr_addr_q + 24'd4 : wr_addr_q;
      wr_data_d  = wr_data_q;
      underrun_d = 1'b0;
      cmd_err_d  = 1'b0;
      if (rd_ack && pend_q) begin
         hold_d   = rd_data;
         hold_v_d = 1'b1;
         pend_d   = 1'b0;
      end
      if (cs_q[1]) begin
         state_d  = IDLE;
         cnt_d    = '0;
         io_oe_d  = '0;
         io_out_d = '0;
         hold_v_d = 1'b0;
         pend_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = CMD;
               cnt_d   = '0;
            end
            CMD: if (rise) begin
               cmd_d = cmd_sh;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd7) begin
                  cnt_d     = '0;
                  shift_d   = {JEDEC_ID, 8'hFF};
                  state_d   = cmd_sh == 8'h9F ? ID :
                              cmd_sh inside {8'h03, 8'h0B, 8'h3B, 8'h6B, 8'h02} ? ADDR : IGNORE;
                  cmd_err_d = !(cmd_sh inside {8'h03, 8'h0B, 8'h3B, 8'h6B, 8'h02, 8'h9F});
               end
            end
            ADDR: if (rise) begin
               addr_d = addr_sh;
               cnt_d  = cnt_q + 6'd1;
               if (cnt_q == 6'd23) begin
                  cnt_d = '0;
                  if (rd_cmd) begin
                     rd_req_d  = 1'b1;
                     rd_addr_d = {addr_sh[23:2], 2'b00};
                     pend_d    = 1'b1;
                     hold_v_d  = 1'b0;
                     state_d   = cmd_q == 8'h03 ? RDATA : DUMMY;
                  end else begin
                     wr_addr_d = {addr_sh[23:2], 2'b00};
                     state_d   = WDATA;
                  end
               end
            end
            DUMMY: if (rise) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = RDATA;
               end
            end
            RDATA: if (fall) begin
               io_out_d = quad ? word[31:28] : dual ? {2'b00, word[31:30]} : {2'b00, word[31], 1'b0};
               io_oe_d  = quad ? 4'hF : dual ? 4'h3 : 4'h2;
               shift_d  = quad ? word << 4 : dual ? word << 2 : word << 1;
               cnt_d    = cnt_q == last ? 6'd0 : cnt_q + 6'd1;
               if (cnt_q == 6'd0) begin
                  hold_v_d   = 1'b0;
                  underrun_d = !hold_v_q;
                  rd_req_d   = 1'b1;
                  rd_addr_d  = rd_addr_q + 24'd4;
                  pend_d     = 1'b1;
               end
            end
            WDATA: if (rise) begin
               shift_d = wsh;
               cnt_d   = cnt_q == 6'd31 ? 6'd0 : cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = wsh;
               end
            end
            ID: if (fall) begin
               io_out_d = {2'b00, shift_q[31], 1'b0};
               io_oe_d  = 4'b0010;
               shift_d  = {shift_q[30:0], 1'b1};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q     <= '0;
         cs_q       <= '1;
         io_q       <= '0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         addr_q     <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_v_q   <= 1'b0;
         pend_q     <= 1'b0;
         io_out_q   <= '0;
         io_oe_q    <= '0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         underrun_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         sclk_q     <= {sclk_q[1:0], sclk};
         cs_q       <= {cs_q[0], cs_n};
         io_q       <= {io_q[0], io_in[0]};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_v_q   <= hold_v_d;
         pend_q     <= pend_d;
         io_out_q   <= io_out_d;
         io_oe_q    <= io_oe_d;
         rd_req_q   <= rd_req_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         underrun_q <= underrun_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign io_out   = io_out_q;
   assign io_oe    = io_oe_q;
   assign rd_req   = rd_req_q;
   assign rd_addr  = rd_addr_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = ~cs_q[1];
   assign underrun = underrun_q;
   assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI master driving the responder, checked against a transaction-level
// model (flash memory map, JEDEC ID, expected backend request/write streams).
`timescale 1ns/1ps
module tb_spi_flash_responder;
   localparam int          H     = 4;
   localparam int          DUMMY = 8;
   localparam logic [23:0] JEDEC = 24'hC22017;

   logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
   logic [3:0]  io_in = 4'h0;
   logic [3:0]  io_out, io_oe;
   logic        rd_req, rd_ack = 1'b0, wr_en, busy, underrun, cmd_err;
   logic [23:0] rd_addr, wr_addr;
   logic [31:0] rd_data = '0, wr_data;

   int          total = 0, bad = 0, und_n = 0, cerr_n = 0, oe_viol = 0;
   bit          noack = 1'b0;
   logic [31:0] salt;
   logic [31:0] mem [logic [23:0]];
   logic [23:0] rdq[$], wq_a[$];
   logic [31:0] wq_d[$];
   logic [7:0]  pick [4] = '{8'h03, 8'h0B, 8'h3B, 8'h6B};

   always #5 clk = ~clk;

   spi_flash_responder #(.DUMMY_CYCLES(DUMMY), .JEDEC_ID(JEDEC)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .io_in(io_in),
      .io_out(io_out), .io_oe(io_oe), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .underrun(underrun), .cmd_err(cmd_err)
   );

   function automatic logic [31:0] memval(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : ({8'h00, a} * 32'h9E3779B1) ^ salt;
   endfunction

   // Backend answers one clk after each request; monitors log traffic
   always @(negedge clk) begin
      rd_ack = rd_req && !noack && rst_n;
      if (rd_ack) rd_data = memval(rd_addr);
      if (rst_n) begin
         if (rd_req) rdq.push_back(rd_addr);
         if (wr_en) begin
            wq_a.push_back(wr_addr);
            wq_d.push_back(wr_data);
         end
         if (underrun) und_n++;
         if (cmd_err) cerr_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
      io_in = d;
      repeat (H) @(negedge clk);
      q = io_out;
      oe = io_oe;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int n);
      logic [3:0] q, oe;
      for (int i = n - 1; i >= 0; i--) begin
         xfer({3'b000, v[i]}, q, oe);
         if (oe !== 4'h0) oe_viol++;
      end
   endtask

   task automatic recv(input int w, input int nbits, output logic [63:0] data, output int oe_bad);
      logic [3:0] q, oe, want;
      data = '0;
      oe_bad = 0;
      want = w == 4 ? 4'hF : w == 2 ? 4'h3 : 4'h2;
      for (int k = 0; k < nbits / w; k++) begin
         xfer(4'h0, q, oe);
         data = w == 4 ? {data[59:0], q} : w == 2 ? {data[61:0], q[1:0]} : {data[62:0], q[1]};
         if (oe !== want) oe_bad++;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_end();
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic read_txn(input logic [7:0] cmd, input logic [23:0] a, input int nbits,
                           output logic [63:0] data, output int oe_bad);
      cs_begin();
      send({24'h0, cmd}, 8);
      send({8'h0, a}, 24);
      if (cmd != 8'h03) send(0, DUMMY);
      recv(cmd == 8'h6B ? 4 : cmd == 8'h3B ? 2 : 1, nbits, data, oe_bad);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctl"}, {io_out, io_oe, rd_req, wr_en, busy, underrun, cmd_err}, 0);
      chk({tag, "_addr"}, {rd_addr, wr_addr}, 0);
      chk({tag, "_wdata"}, wr_data, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] d, expd;
      logic [23:0] a, b;
      logic [7:0]  c;
      int          ob, u0;
      salt = $urandom;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // READ ID
      cs_begin();
      chk("busy_high", busy, 1);
      oe_viol = 0;
      send(32'h9F, 8);
      recv(1, 32, d, ob);
      chk("id_bits", d, {32'h0, JEDEC, 8'hFF});
      chk("id_oe", ob, 0);
      chk("id_cmd_oe", oe_viol, 0);
      cs_end();
      chk("busy_low", busy, 0);
      chk("oe_idle", io_oe, 0);

      // Directed single read across a word boundary
      mem[24'h104] = 32'hDEADBEEF;
      mem[24'h108] = 32'h01234567;
      rdq.delete();
      read_txn(8'h03, 24'h000104, 64, d, ob);
      cs_end();
      chk("rd03_data", d, 64'hDEADBEEF01234567);
      chk("rd03_oe", ob, 0);
      chk("rd03_addrs", rdq.size() >= 2 ? {rdq[0], rdq[1]} : '1, {24'h104, 24'h108});

      // Randomized reads in all modes, first one wraps the address space
      u0 = und_n;
      for (int it = 0; it < 5; it++) begin
         c = it == 0 ? 8'h0B : pick[$urandom_range(0, 3)];
         a = it == 0 ? 24'hFFFFFE : 24'($urandom);
         b = {a[23:2], 2'b00};
         expd = {memval(b), memval(b + 24'd4)};
         rdq.delete();
         read_txn(c, a, 64, d, ob);
         cs_end();
         chk($sformatf("rnd_rd%0d_%0h_data", it, c), d, expd);
         chk($sformatf("rnd_rd%0d_oe", it), ob, 0);
         chk($sformatf("rnd_rd%0d_addrs", it), rdq.size() >= 2 ? {rdq[0], rdq[1]} : '1, {b, b + 24'd4});
      end
      chk("no_underrun", und_n - u0, 0);

      // Quad read with a silent backend
      noack = 1'b1;
      u0 = und_n;
      read_txn(8'h6B, 24'h000010, 32, d, ob);
      chk("ur_count", und_n - u0, 1);
      cs_end();
      noack = 1'b0;
      chk("ur_data", d, 64'hFFFFFFFF);
      chk("ur_oe", ob, 0);

      // Write with a trailing partial word
      wq_a.delete();
      wq_d.delete();
      oe_viol = 0;
      d = {$urandom, $urandom};
      cs_begin();
      send(32'h02, 8);
      send(32'h20, 24);
      send(d[63:32], 32);
      send(d[31:0], 8);
      cs_end();
      chk("wr_count", wq_a.size(), 1);
      chk("wr_addr", wq_a.size() >= 1 ? wq_a[0] : '1, 24'h20);
      chk("wr_data", wq_d.size() >= 1 ? wq_d[0] : '1, d[63:32]);
      chk("wr_oe", oe_viol, 0);

      // Randomized two-word writes, first one wraps
      for (int it = 0; it < 2; it++) begin
         a = it == 0 ? 24'hFFFFFD : 24'($urandom);
         b = {a[23:2], 2'b00};
         d = {$urandom, $urandom};
         wq_a.delete();
         wq_d.delete();
         cs_begin();
         send(32'h02, 8);
         send({8'h0, a}, 24);
         send(d[63:32], 32);
         send(d[31:0], 32);
         cs_end();
         chk($sformatf("rnd_wr%0d_count", it), wq_a.size(), 2);
         chk($sformatf("rnd_wr%0d_addrs", it), wq_a.size() >= 2 ? {wq_a[0], wq_a[1]} : '1, {b, b + 24'd4});
         chk($sformatf("rnd_wr%0d_data", it), wq_d.size() >= 2 ? {wq_d[0], wq_d[1]} : '1, d);
      end

      // Unsupported command, then a normal transaction
      u0 = cerr_n;
      oe_viol = 0;
      cs_begin();
      send(32'h5A, 8);
      send($urandom, 16);
      chk("cmd_err", cerr_n - u0, 1);
      chk("ign_oe", oe_viol, 0);
      chk("ign_oe_now", io_oe, 0);
      cs_end();
      cs_begin();
      send(32'h9F, 8);
      recv(1, 32, d, ob);
      cs_end();
      chk("id_again", d, {32'h0, JEDEC, 8'hFF});
      chk("cmd_err_total", cerr_n, 1);

      // Reset in the middle of a read
      read_txn(8'h03, 24'h000040, 10, d, ob);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      expd = {memval(24'h0), memval(24'h4)};
      rdq.delete();
      read_txn(8'h3B, 24'h000000, 64, d, ob);
      cs_end();
      chk("dual_data", d, expd);
      chk("dual_oe", ob, 0);
      chk("dual_addrs", rdq.size() >= 2 ? {rdq[0], rdq[1]} : '1, {24'h0, 24'h4});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
